dual_issue_ctrl: RTL and testbench

- Issue stage directly downstream of the instruction buffer.
- Each cycle it samples the buffer head pair (inst1/inst2 with PCs and valids) and picks dual, single or no issue under structural, RAW, branch/delay-slot and load-use rules.
- It returns the pop request (issue_o, issue_mode_o) to the buffer and registers the chosen instructions into two ID lanes.
- It keeps per-mode issue counters for performance analysis.

---
 rtl/dual_issue_ctrl_pkg.sv | 60 ++++++
 rtl/dual_issue_ctrl_decode.sv | 59 +++++
 rtl/dual_issue_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dual_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types and encodings for the dual-issue stage: issue modes, the
// per-instruction decode record and the MIPS opcode/funct values it needs.
package dual_issue_ctrl_pkg;

    // Pop width reported back to the instruction buffer.
    typedef enum logic {
        SingleIssue = 1'b0,
        DualIssue   = 1'b1
    } issue_mode_e;

    // Internal per-cycle decision of the issue stage.
    typedef enum logic [1:0] {
        DecNone   = 2'd0,
        DecSingle = 2'd1,
        DecDual   = 2'd2
    } issue_dec_e;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_COP0    = 6'b010000;

    // SPECIAL funct codes
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_BREAK   = 6'b001101;

    // Opcode groups (opcode[5:3])
    localparam logic [2:0] GRP_ALU_IMM = 3'b001;
    localparam logic [2:0] GRP_LOAD    = 3'b100;
    localparam logic [2:0] GRP_STORE   = 3'b101;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Register usage and class of a single instruction. A source or
    // destination field of zero means "none" since $0 never hazards.
    typedef struct packed {
        logic [4:0] dst;
        logic [4:0] src1;
        logic [4:0] src2;
        logic       is_branch;
        logic       is_mem;
        logic       is_muldiv;
        logic       is_priv;
    } dec_info_t;

    // Loads are the only producers whose result is late enough to stall.
    function automatic logic is_load(input logic [31:0] inst);
        return inst[31:29] == GRP_LOAD;
    endfunction

endpackage

// File: rtl/dual_issue_ctrl_decode.sv
// Lightweight pre-decode of one instruction: classifies it and extracts the
// register numbers the issue checks care about. Purely combinational.
module dual_issue_ctrl_decode
    import dual_issue_ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_info_t   info_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_special;

    assign op         = inst_i[31:26];
    assign rs         = inst_i[25:21];
    assign rt         = inst_i[20:16];
    assign rd         = inst_i[15:11];
    assign fn         = inst_i[5:0];
    assign is_special = (op == OP_SPECIAL);

    // Class flags plus destination/source extraction for the hazard checks.
    always_comb begin
        info_o = '0;

        info_o.is_branch = (op inside {OP_REGIMM, OP_J, OP_JAL, OP_BEQ,
                                       OP_BNE, OP_BLEZ, OP_BGTZ})
                         || (is_special && (fn inside {FN_JR, FN_JALR}));

        info_o.is_mem    = (op[5:4] == 2'b10);

        info_o.is_muldiv = is_special
                         && ((fn[5:2] == 4'b0100) || (fn[5:2] == 4'b0110));

        info_o.is_priv   = (op == OP_COP0)
                         || (is_special && (fn inside {FN_SYSCALL, FN_BREAK}));

        if (is_special) begin
            info_o.dst = rd;
        end else if ((op[5:3] == GRP_ALU_IMM) || (op[5:3] == GRP_LOAD)) begin
            info_o.dst = rt;
        end else if (op == OP_JAL) begin
            info_o.dst = REG_RA;
        end else begin
            info_o.dst = REG_ZERO;
        end

        info_o.src1 = rs;
        if (is_special || (op == OP_BEQ) || (op == OP_BNE)
            || (op[5:3] == GRP_STORE)) begin
            info_o.src2 = rt;
        end else begin
            info_o.src2 = REG_ZERO;
        end
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue stage behind the instruction buffer. Chooses dual, single or no issue
// for the head pair, tells the buffer how many to pop, and registers the
// chosen instructions into the two ID lanes. Keeps per-mode issue counters.
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall_i,
    input  logic [31:0]      inst1_i,
    input  logic [31:0]      inst2_i,
    input  logic [31:0]      pc1_i,
    input  logic [31:0]      pc2_i,
    input  logic             valid1_i,
    input  logic             valid2_i,
    output logic             issue_o,
    output logic             issue_mode_o,
    output logic [31:0]      lane1_inst_o,
    output logic [31:0]      lane2_inst_o,
    output logic [31:0]      lane1_pc_o,
    output logic [31:0]      lane2_pc_o,
    output logic             lane1_valid_o,
    output logic             lane2_valid_o,
    output logic [CNT_W-1:0] dual_cnt_o,
    output logic [CNT_W-1:0] single_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    dec_info_t info1;
    dec_info_t info2;

    dual_issue_ctrl_decode u_dec1 (
        .inst_i (inst1_i),
        .info_o (info1)
    );

    dual_issue_ctrl_decode u_dec2 (
        .inst_i (inst2_i),
        .info_o (info2)
    );

    // Destination of a load issued last cycle (0 = none pending).
    logic [4:0]       load_dst_q, load_dst_d;

    logic [31:0]      lane1_inst_q, lane1_inst_d;
    logic [31:0]      lane2_inst_q, lane2_inst_d;
    logic [31:0]      lane1_pc_q,   lane1_pc_d;
    logic [31:0]      lane2_pc_q,   lane2_pc_d;
    logic             lane1_valid_q, lane1_valid_d;
    logic             lane2_valid_q, lane2_valid_d;
    logic [CNT_W-1:0] dual_cnt_q,   dual_cnt_d;
    logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic       active;
    logic       ld_use1;
    logic       ld_use2;
    logic       raw_12;
    logic       struct_12;
    issue_dec_e dec;

    assign active = !rst && !flush && !stall_i;

    // Hazard terms: load-use against the pending load, and intra-pair RAW.
    always_comb begin
        ld_use1   = (load_dst_q != REG_ZERO)
                  && ((info1.src1 == load_dst_q) || (info1.src2 == load_dst_q));
        ld_use2   = (load_dst_q != REG_ZERO)
                  && ((info2.src1 == load_dst_q) || (info2.src2 == load_dst_q));
        raw_12    = (info1.dst != REG_ZERO)
                  && ((info2.src1 == info1.dst) || (info2.src2 == info1.dst));
        struct_12 = (info1.is_mem && info2.is_mem)
                  || (info1.is_muldiv && info2.is_muldiv);
    end

    // Issue decision in priority order. A branch always takes its delay slot
    // along with it; the slot bypasses the pair checks since EX forwards the
    // link value.
    always_comb begin
        dec = DecNone;
        if (!valid1_i) begin
            dec = DecNone;
        end else if (ld_use1) begin
            dec = DecNone;
        end else if (info1.is_branch) begin
            dec = valid2_i ? DecDual : DecNone;
        end else if (info1.is_priv || info2.is_priv || info2.is_branch
                     || !valid2_i) begin
            dec = DecSingle;
        end else if (raw_12 || struct_12 || ld_use2) begin
            dec = DecSingle;
        end else begin
            dec = DecDual;
        end
    end

    assign issue_o      = active && (dec != DecNone);
    assign issue_mode_o = (active && (dec == DecDual)) ? DualIssue : SingleIssue;

    // Next-state for lanes, pending-load tracker and perf counters.
    always_comb begin
        lane1_inst_d  = lane1_inst_q;
        lane2_inst_d  = lane2_inst_q;
        lane1_pc_d    = lane1_pc_q;
        lane2_pc_d    = lane2_pc_q;
        lane1_valid_d = lane1_valid_q;
        lane2_valid_d = lane2_valid_q;
        load_dst_d    = load_dst_q;
        dual_cnt_d    = dual_cnt_q;
        single_cnt_d  = single_cnt_q;
        bubble_cnt_d  = bubble_cnt_q;

        if (!stall_i) begin
            lane1_valid_d = (dec != DecNone);
            lane2_valid_d = (dec == DecDual);
            load_dst_d    = REG_ZERO;

            if (dec != DecNone) begin
                lane1_inst_d = inst1_i;
                lane1_pc_d   = pc1_i;
                if (is_load(inst1_i)) begin
                    load_dst_d = info1.dst;
                end
            end

            if (dec == DecDual) begin
                lane2_inst_d = inst2_i;
                lane2_pc_d   = pc2_i;
                if (is_load(inst2_i)) begin
                    load_dst_d = info2.dst;
                end
            end

            if (valid1_i) begin
                unique case (dec)
                    DecDual:   dual_cnt_d   = dual_cnt_q   + CNT_W'(1);
                    DecSingle: single_cnt_d = single_cnt_q + CNT_W'(1);
                    default:   bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
                endcase
            end
        end
    end

    // State update: reset clears everything, flush clears lanes and the
    // pending load but keeps the counters, stall is folded into _d.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane1_inst_q  <= '0;
            lane2_inst_q  <= '0;
            lane1_pc_q    <= '0;
            lane2_pc_q    <= '0;
            lane1_valid_q <= 1'b0;
            lane2_valid_q <= 1'b0;
            load_dst_q    <= REG_ZERO;
            dual_cnt_q    <= '0;
            single_cnt_q  <= '0;
            bubble_cnt_q  <= '0;
        end else if (flush) begin
            lane1_inst_q  <= '0;
            lane2_inst_q  <= '0;
            lane1_pc_q    <= '0;
            lane2_pc_q    <= '0;
            lane1_valid_q <= 1'b0;
            lane2_valid_q <= 1'b0;
            load_dst_q    <= REG_ZERO;
        end else begin
            lane1_inst_q  <= lane1_inst_d;
            lane2_inst_q  <= lane2_inst_d;
            lane1_pc_q    <= lane1_pc_d;
            lane2_pc_q    <= lane2_pc_d;
            lane1_valid_q <= lane1_valid_d;
            lane2_valid_q <= lane2_valid_d;
            load_dst_q    <= load_dst_d;
            dual_cnt_q    <= dual_cnt_d;
            single_cnt_q  <= single_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign lane1_inst_o  = lane1_inst_q;
    assign lane2_inst_o  = lane2_inst_q;
    assign lane1_pc_o    = lane1_pc_q;
    assign lane2_pc_o    = lane2_pc_q;
    assign lane1_valid_o = lane1_valid_q;
    assign lane2_valid_o = lane2_valid_q;
    assign dual_cnt_o    = dual_cnt_q;
    assign single_cnt_o  = single_cnt_q;
    assign bubble_cnt_o  = bubble_cnt_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl with hand-computed expectations.
// A second instance with 4-bit counters shares the stimulus to show wrap.
module tb_dual_issue_ctrl;

    localparam logic [31:0] ADDU_3_1_2 = 32'h00221821; // addu $3,$1,$2
    localparam logic [31:0] ADDU_4_3_5 = 32'h00652021; // addu $4,$3,$5
    localparam logic [31:0] ADDU_7_5_6 = 32'h00A63821; // addu $7,$5,$6
    localparam logic [31:0] ADDU_8_6_0 = 32'h00C04021; // addu $8,$6,$0
    localparam logic [31:0] LW_6       = 32'h8CE60000; // lw $6,0($7)
    localparam logic [31:0] SW_1       = 32'hAC410004; // sw $1,4($2)
    localparam logic [31:0] BEQ_1_2    = 32'h10220003; // beq $1,$2
    localparam logic [31:0] MULT_1_2   = 32'h00220018; // mult $1,$2
    localparam logic [31:0] DIV_3_4    = 32'h0064001A; // div $3,$4
    localparam logic [31:0] SYSCALL    = 32'h0000000C;
    localparam logic [31:0] JR_31      = 32'h03E00008;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall;
    logic [31:0] inst1, inst2, pc1, pc2;
    logic        v1, v2;

    logic        issue, mode;
    logic [31:0] l1_inst, l2_inst, l1_pc, l2_pc;
    logic        l1_v, l2_v;
    logic [31:0] dual_cnt, single_cnt, bubble_cnt;

    logic        issue4, mode4;
    logic [31:0] l1_inst4, l2_inst4, l1_pc4, l2_pc4;
    logic        l1_v4, l2_v4;
    logic [3:0]  dual_cnt4, single_cnt4, bubble_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    dual_issue_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall_i       (stall),
        .inst1_i       (inst1),
        .inst2_i       (inst2),
        .pc1_i         (pc1),
        .pc2_i         (pc2),
        .valid1_i      (v1),
        .valid2_i      (v2),
        .issue_o       (issue),
        .issue_mode_o  (mode),
        .lane1_inst_o  (l1_inst),
        .lane2_inst_o  (l2_inst),
        .lane1_pc_o    (l1_pc),
        .lane2_pc_o    (l2_pc),
        .lane1_valid_o (l1_v),
        .lane2_valid_o (l2_v),
        .dual_cnt_o    (dual_cnt),
        .single_cnt_o  (single_cnt),
        .bubble_cnt_o  (bubble_cnt)
    );

    dual_issue_ctrl #(.CNT_W(4)) u_dut4 (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall_i       (stall),
        .inst1_i       (inst1),
        .inst2_i       (inst2),
        .pc1_i         (pc1),
        .pc2_i         (pc2),
        .valid1_i      (v1),
        .valid2_i      (v2),
        .issue_o       (issue4),
        .issue_mode_o  (mode4),
        .lane1_inst_o  (l1_inst4),
        .lane2_inst_o  (l2_inst4),
        .lane1_pc_o    (l1_pc4),
        .lane2_pc_o    (l2_pc4),
        .lane1_valid_o (l1_v4),
        .lane2_valid_o (l2_v4),
        .dual_cnt_o    (dual_cnt4),
        .single_cnt_o  (single_cnt4),
        .bubble_cnt_o  (bubble_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs may change afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i1, input logic [31:0] i2,
                         input logic a, input logic b);
        inst1 = i1;
        inst2 = i2;
        v1    = a;
        v2    = b;
        pc1   = pc1 + 32'd8;
        pc2   = pc1 + 32'd4;
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        inst1 = ADDU_3_1_2;
        inst2 = ADDU_7_5_6;
        pc1   = 32'h0000_00F8;
        pc2   = 32'h0000_00FC;
        v1    = 1'b1;
        v2    = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_issue", issue, 0);
        check("rst_l1v", l1_v, 0);
        check("rst_l2v", l2_v, 0);
        check("rst_dual", dual_cnt, 0);
        rst = 1'b0;

        // RAW between the pair -> single
        drive(ADDU_3_1_2, ADDU_4_3_5, 1, 1);
        check("raw_issue", issue, 1);
        check("raw_mode", mode, 0);
        tick();
        check("raw_l1inst", l1_inst, ADDU_3_1_2);
        check("raw_l1pc", l1_pc, 32'h100);
        check("raw_l1v", l1_v, 1);
        check("raw_l2v", l2_v, 0);
        check("raw_single", single_cnt, 1);

        // Both memory ops -> single; lw $6 becomes the pending load
        drive(LW_6, SW_1, 1, 1);
        check("mem_issue", issue, 1);
        check("mem_mode", mode, 0);
        tick();
        check("mem_single", single_cnt, 2);
        check("mem_l1inst", l1_inst, LW_6);

        // Load-use on inst1 -> bubble
        drive(ADDU_8_6_0, ADDU_4_3_5, 1, 0);
        check("lu_issue", issue, 0);
        tick();
        check("lu_l1v", l1_v, 0);
        check("lu_l2v", l2_v, 0);
        check("lu_bubble", bubble_cnt, 1);
        check("lu_single", single_cnt, 2);
        // Load tracker cleared, same instruction now goes
        check("lu_resume_issue", issue, 1);
        check("lu_resume_mode", mode, 0);
        tick();
        check("lu_resume_l1v", l1_v, 1);
        check("lu_resume_single", single_cnt, 3);

        // Branch waits for its delay slot
        drive(BEQ_1_2, ADDU_4_3_5, 1, 0);
        check("br_wait_issue", issue, 0);
        tick();
        check("br_wait_l1v", l1_v, 0);
        check("br_wait_bubble", bubble_cnt, 2);
        drive(BEQ_1_2, ADDU_4_3_5, 1, 1);
        check("br_issue", issue, 1);
        check("br_mode", mode, 1);
        tick();
        check("br_l1v", l1_v, 1);
        check("br_l2v", l2_v, 1);
        check("br_l1inst", l1_inst, BEQ_1_2);
        check("br_l2inst", l2_inst, ADDU_4_3_5);
        check("br_l2pc", l2_pc, pc2);
        check("br_dual", dual_cnt, 1);

        // Stall three cycles with an independent pair waiting
        stall = 1'b1;
        drive(ADDU_3_1_2, ADDU_7_5_6, 1, 1);
        check("stall_issue", issue, 0);
        tick();
        tick();
        check("stall_issue_mid", issue, 0);
        tick();
        check("stall_l1inst", l1_inst, BEQ_1_2);
        check("stall_l2inst", l2_inst, ADDU_4_3_5);
        check("stall_l2v", l2_v, 1);
        check("stall_dual", dual_cnt, 1);
        check("stall_single", single_cnt, 3);
        check("stall_bubble", bubble_cnt, 2);
        stall = 1'b0;
        #1;
        check("unstall_issue", issue, 1);
        check("unstall_mode", mode, 1);
        tick();
        check("unstall_dual", dual_cnt, 2);
        check("unstall_l2inst", l2_inst, ADDU_7_5_6);

        // Structural: two mul/div ops
        drive(MULT_1_2, DIV_3_4, 1, 1);
        check("md_mode", mode, 0);
        tick();
        check("md_single", single_cnt, 4);
        check("md_l2v", l2_v, 0);

        // Privileged inst2
        drive(ADDU_3_1_2, SYSCALL, 1, 1);
        check("priv_mode", mode, 0);
        tick();
        check("priv_single", single_cnt, 5);

        // Branch in inst2 must not pair
        drive(ADDU_3_1_2, JR_31, 1, 1);
        check("br2_mode", mode, 0);
        check("br2_issue", issue, 1);
        tick();
        check("br2_single", single_cnt, 6);

        // inst2 load-use -> single
        drive(LW_6, ADDU_4_3_5, 1, 0);
        tick();
        check("ld2_prep_single", single_cnt, 7);
        drive(ADDU_3_1_2, ADDU_8_6_0, 1, 1);
        check("ld2_issue", issue, 1);
        check("ld2_mode", mode, 0);
        tick();
        check("ld2_single", single_cnt, 8);

        // Flush (with stall also high) clears lanes and the pending load
        drive(LW_6, ADDU_4_3_5, 1, 0);
        tick();
        check("fl_prep_single", single_cnt, 9);
        flush = 1'b1;
        stall = 1'b1;
        drive(ADDU_3_1_2, ADDU_7_5_6, 1, 1);
        check("fl_issue", issue, 0);
        tick();
        check("fl_l1v", l1_v, 0);
        check("fl_l2v", l2_v, 0);
        check("fl_l1inst", l1_inst, 0);
        check("fl_dual", dual_cnt, 2);
        check("fl_single", single_cnt, 9);
        check("fl_bubble", bubble_cnt, 2);
        flush = 1'b0;
        stall = 1'b0;
        drive(ADDU_8_6_0, ADDU_4_3_5, 1, 0);
        check("fl_noload_issue", issue, 1);
        tick();
        check("fl_noload_single", single_cnt, 10);

        // Reset clears counters too
        rst = 1'b1;
        tick();
        check("rst2_dual", dual_cnt, 0);
        check("rst2_single", single_cnt, 0);
        check("rst2_bubble", bubble_cnt, 0);
        check("rst2_l1v", l1_v, 0);
        check("rst2_l1inst", l1_inst, 0);
        rst = 1'b0;

        // Counter wrap on the 4-bit instance
        drive(ADDU_3_1_2, ADDU_4_3_5, 1, 0);
        for (int i = 0; i < 15; i++) tick();
        check("wrap_pre4", single_cnt4, 15);
        check("wrap_pre32", single_cnt, 15);
        tick();
        check("wrap_post4", single_cnt4, 0);
        check("wrap_post32", single_cnt, 16);
        v1 = 1'b0;
        #1;
        check("idle_issue", issue, 0);
        tick();
        check("idle_bubble", bubble_cnt, 0);
        check("idle_l1v", l1_v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
